main_memory_responder: RTL and testbench

// - Memory-side responder for the processing_block load/write interface.
// - Services one load and one write per cycle on wide lines of CORES*BITS bits.
// - Returns load data after a fixed, parameterised latency, with a valid strobe.
// - Zero-clears its storage after every reset before it accepts requests.
//

---
 rtl/main_memory_responder_if.sv | 33 +++
 rtl/main_memory_responder.sv | 124 ++++++++++++
 tb/tb_main_memory_responder.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/main_memory_responder_if.sv
`default_nettype none
// ============================================================================
// main_memory_responder_if : load/write request and response bundle
// Rev 1.0 - initial release
// ============================================================================
interface main_memory_responder_if #(
  parameter int CORES = 32,
  parameter int BITS  = 16
);
  localparam int LW = CORES * BITS;

  logic          load_ctrl;
  logic [15:0]   load_addr;
  logic          write_ctrl;
  logic [15:0]   write_addr_main;
  logic [LW-1:0] write_data_main;
  logic [LW-1:0] load_data;
  logic          load_valid;
  logic          load_err;
  logic          write_err;
  logic          ready;

  modport master (
    output load_ctrl, load_addr, write_ctrl, write_addr_main, write_data_main,
    input  load_data, load_valid, load_err, write_err, ready
  );

  modport slave (
    input  load_ctrl, load_addr, write_ctrl, write_addr_main, write_data_main,
    output load_data, load_valid, load_err, write_err, ready
  );
endinterface
`default_nettype wire

// File: rtl/main_memory_responder.sv
`default_nettype none
// ============================================================================
// main_memory_responder : wide-line memory with fixed-latency loads, self-clearing after reset
// Rev 1.0 - initial release
// ============================================================================
module main_memory_responder #(
  parameter int CORES        = 32,
  parameter int BITS         = 16,
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 2
) (
  input  logic                    clock,
  input  logic                    reset_n,
  main_memory_responder_if.slave  bus
);

  localparam int          c_LW      = CORES * BITS;
  localparam int          c_AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] c_DEPTH32 = 32'(DEPTH);
  localparam logic [c_AW-1:0] c_LAST = c_AW'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_ready;
  logic              w_clr_en;
  logic [c_AW-1:0]   r_clr_cnt;
  logic [c_LW-1:0]   r_mem [DEPTH];

  logic              w_load_inr;
  logic              w_wr_inr;
  logic              w_acc_load;
  logic              w_acc_write;
  logic              w_wr_ok;
  logic [c_AW-1:0]   w_load_idx;
  logic [c_AW-1:0]   w_wr_idx;
  logic [c_LW-1:0]   w_rd_data;

  logic              r_vld_q [READ_LATENCY];
  logic              r_err_q [READ_LATENCY];
  logic [c_LW-1:0]   r_dat_q [READ_LATENCY];
  logic              r_write_err;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_INIT;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_clr_en    = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_clr_en = 1'b1;
        if (r_clr_cnt == c_LAST) w_state_nxt = ST_RUN;
      end
      ST_RUN:  w_ready = 1'b1;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)      r_clr_cnt <= '0;
    else if (w_clr_en) r_clr_cnt <= r_clr_cnt + 1'b1;
  end

  // Range checks use the full 16-bit address so high bits can never alias into storage.
  assign w_load_inr  = (32'(bus.load_addr) < c_DEPTH32);
  assign w_wr_inr    = (32'(bus.write_addr_main) < c_DEPTH32);
  assign w_acc_load  = w_ready & bus.load_ctrl;
  assign w_acc_write = w_ready & bus.write_ctrl;
  assign w_wr_ok     = w_acc_write & w_wr_inr;
  assign w_load_idx  = bus.load_addr[c_AW-1:0];
  assign w_wr_idx    = bus.write_addr_main[c_AW-1:0];

  // Write-first forwarding when load and write hit the same line in one cycle.
  always_comb begin
    w_rd_data = '0;
    if (w_load_inr) begin
      if (w_wr_ok && (w_wr_idx == w_load_idx)) w_rd_data = bus.write_data_main;
      else                                     w_rd_data = r_mem[w_load_idx];
    end
  end

  always_ff @(posedge clock) begin
    if (w_clr_en)     r_mem[r_clr_cnt] <= '0;
    else if (w_wr_ok) r_mem[w_wr_idx]  <= bus.write_data_main;
  end

  // Stage READ_LATENCY-1 is the output register; data stages only move with a valid, so outputs hold.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        r_vld_q[i] <= 1'b0;
        r_err_q[i] <= 1'b0;
        r_dat_q[i] <= '0;
      end
      r_write_err <= 1'b0;
    end else begin
      r_vld_q[0] <= w_acc_load;
      r_err_q[0] <= w_acc_load & ~w_load_inr;
      if (w_acc_load) r_dat_q[0] <= w_rd_data;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_vld_q[i] <= r_vld_q[i-1];
        r_err_q[i] <= r_err_q[i-1];
        if (r_vld_q[i-1]) r_dat_q[i] <= r_dat_q[i-1];
      end
      r_write_err <= w_acc_write & ~w_wr_inr;
    end
  end

  assign bus.load_data  = r_dat_q[READ_LATENCY-1];
  assign bus.load_valid = r_vld_q[READ_LATENCY-1];
  assign bus.load_err   = r_err_q[READ_LATENCY-1];
  assign bus.write_err  = r_write_err;
  assign bus.ready      = w_ready;

endmodule
`default_nettype wire

// File: tb/tb_main_memory_responder.sv
`default_nettype none
// ============================================================================
// tb_main_memory_responder : directed self-checking bench for main_memory_responder
// Rev 1.0 - initial release
// ============================================================================
module tb_main_memory_responder;

  localparam int CORES        = 32;
  localparam int BITS         = 16;
  localparam int DEPTH        = 1024;
  localparam int READ_LATENCY = 2;
  localparam int LW           = CORES * BITS;

  logic clock;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  main_memory_responder_if #(.CORES(CORES), .BITS(BITS)) bus ();

  main_memory_responder #(
    .CORES(CORES), .BITS(BITS), .DEPTH(DEPTH), .READ_LATENCY(READ_LATENCY)
  ) u_dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Lane j of pattern s holds {s, j} so lane ordering errors are visible.
  function automatic logic [LW-1:0] pat(input logic [7:0] seed);
    logic [LW-1:0] p;
    for (int j = 0; j < CORES; j++) p[j*BITS +: BITS] = {seed, 8'(j)};
    return p;
  endfunction

  task automatic idle_bus();
    bus.load_ctrl       = 1'b0;
    bus.load_addr       = '0;
    bus.write_ctrl      = 1'b0;
    bus.write_addr_main = '0;
    bus.write_data_main = '0;
  endtask

  // Called at a negedge right after reset release; requests are driven throughout INIT and must be ignored.
  task automatic wait_ready(input string tag);
    int cycles;
    int strobes;
    cycles  = 0;
    strobes = 0;
    bus.load_ctrl       = 1'b1;
    bus.load_addr       = 16'd5;
    bus.write_ctrl      = 1'b1;
    bus.write_addr_main = 16'd5;
    bus.write_data_main = '1;
    while (cycles < 2*DEPTH) begin
      @(negedge clock);
      cycles++;
      if (bus.ready) break;
      if (bus.load_valid || bus.load_err || bus.write_err) strobes++;
    end
    idle_bus();
    check({tag, "_init_cycles"}, LW'(cycles), LW'(DEPTH));
    check({tag, "_init_strobes"}, LW'(strobes), LW'(0));
  endtask

  task automatic write_line(input logic [15:0] addr, input logic [LW-1:0] data);
    bus.write_ctrl      = 1'b1;
    bus.write_addr_main = addr;
    bus.write_data_main = data;
    @(negedge clock);
    idle_bus();
  endtask

  task automatic load_check(input string tag, input logic [15:0] addr,
                            input logic [LW-1:0] exp, input logic exp_err);
    bus.load_ctrl = 1'b1;
    bus.load_addr = addr;
    @(negedge clock);
    idle_bus();
    repeat (READ_LATENCY - 1) @(negedge clock);
    check({tag, "_valid"}, LW'(bus.load_valid), LW'(1));
    check({tag, "_data"}, bus.load_data, exp);
    check({tag, "_err"}, LW'(bus.load_err), LW'(exp_err));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle_bus();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_ready", LW'(bus.ready), LW'(0));
    check("rst_valid", LW'(bus.load_valid), LW'(0));
    check("rst_data", bus.load_data, '0);
    check("rst_lerr", LW'(bus.load_err), LW'(0));
    check("rst_werr", LW'(bus.write_err), LW'(0));
    reset_n = 1'b1;
    wait_ready("first");

    load_check("zero0", 16'd0, '0, 1'b0);
    load_check("zero5", 16'd5, '0, 1'b0);
    load_check("zerolast", 16'(DEPTH - 1), '0, 1'b0);

    write_line(16'd3, {CORES{16'hA5A5}});
    load_check("wr_rd3", 16'd3, {CORES{16'hA5A5}}, 1'b0);

    // A write one cycle after the load is accepted must not leak into that load.
    bus.load_ctrl = 1'b1;
    bus.load_addr = 16'd3;
    @(negedge clock);
    idle_bus();
    bus.write_ctrl      = 1'b1;
    bus.write_addr_main = 16'd3;
    bus.write_data_main = pat(8'h33);
    @(negedge clock);
    idle_bus();
    check("inflight_valid", LW'(bus.load_valid), LW'(1));
    check("inflight_data", bus.load_data, {CORES{16'hA5A5}});
    load_check("after_wr3", 16'd3, pat(8'h33), 1'b0);

    bus.write_ctrl      = 1'b1;
    bus.write_addr_main = 16'd7;
    bus.write_data_main = pat(8'h77);
    load_check("wfirst7", 16'd7, pat(8'h77), 1'b0);

    for (int i = 0; i < 4; i++) write_line(16'(i), pat(8'(8'hC0 + i)));
    for (int i = 0; i < 4 + READ_LATENCY; i++) begin
      if (i < 4) begin
        bus.load_ctrl = 1'b1;
        bus.load_addr = 16'(i);
      end else begin
        idle_bus();
      end
      @(negedge clock);
      if (i >= READ_LATENCY - 1 && i < 3 + READ_LATENCY) begin
        check($sformatf("b2b%0d_valid", i - READ_LATENCY + 1), LW'(bus.load_valid), LW'(1));
        check($sformatf("b2b%0d_data", i - READ_LATENCY + 1), bus.load_data,
              pat(8'(8'hC0 + i - READ_LATENCY + 1)));
      end
    end
    check("hold_valid", LW'(bus.load_valid), LW'(0));
    check("hold_data", bus.load_data, pat(8'hC3));

    write_line(16'(DEPTH - 1), pat(8'h5E));
    bus.load_ctrl       = 1'b1;
    bus.load_addr       = 16'(DEPTH);
    bus.write_ctrl      = 1'b1;
    bus.write_addr_main = 16'hFFFF;
    bus.write_data_main = pat(8'hEE);
    @(negedge clock);
    idle_bus();
    check("oor_werr", LW'(bus.write_err), LW'(1));
    check("oor_early_valid", LW'(bus.load_valid), LW'(0));
    repeat (READ_LATENCY - 1) @(negedge clock);
    check("oor_valid", LW'(bus.load_valid), LW'(1));
    check("oor_lerr", LW'(bus.load_err), LW'(1));
    check("oor_data", bus.load_data, '0);
    check("oor_werr_off", LW'(bus.write_err), LW'(0));
    @(negedge clock);
    check("oor_lerr_off", LW'(bus.load_err), LW'(0));
    load_check("last_kept", 16'(DEPTH - 1), pat(8'h5E), 1'b0);
    load_check("zero_kept", 16'd0, pat(8'hC0), 1'b0);

    bus.load_ctrl = 1'b1;
    bus.load_addr = 16'd1;
    @(negedge clock);
    bus.load_addr = 16'd2;
    #2 reset_n = 1'b0;
    idle_bus();
    @(negedge clock);
    check("midrst_valid", LW'(bus.load_valid), LW'(0));
    check("midrst_ready", LW'(bus.ready), LW'(0));
    reset_n = 1'b1;
    wait_ready("second");
    load_check("recl1", 16'd1, '0, 1'b0);
    load_check("recl3", 16'd3, '0, 1'b0);
    load_check("recllast", 16'(DEPTH - 1), '0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
